// File: rtl/serial_operand_loader.sv
// Parallel-to-serial operand loader feeding the bit-serial adder: accepts an
// operand pair plus carry-in and emits it LSB-first with framing strobes.
module serial_operand_loader #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic             ser_en,
    output logic             a,
    output logic             b,
    output logic             cin,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sreg_a;
    logic [WIDTH-1:0] sreg_b;
    logic [CW-1:0]    bit_cnt;
    logic             cin_lat;
    logic             done_q;
    logic             load;

    // Handshake: a word transfers on any rising edge where in_valid && in_ready.
    // in_ready never looks at in_valid; it opens in IDLE and on a consumed last
    // bit so the next word follows with no idle cycle.
    assign busy      = (state == SHIFT);
    assign first_bit = busy && (bit_cnt == '0);
    assign last_bit  = busy && (bit_cnt == LAST_IDX);
    assign bit_valid = busy && ser_en;
    assign in_ready  = rst_n && ((state == IDLE) || (last_bit && ser_en));
    assign load      = in_valid && in_ready;

    assign a    = sreg_a[0];
    assign b    = sreg_b[0];
    assign cin  = first_bit && cin_lat;
    assign done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg_a  <= '0;
            sreg_b  <= '0;
            bit_cnt <= '0;
            cin_lat <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= bit_valid && last_bit;
            if (load) begin
                state   <= SHIFT;
                sreg_a  <= op_a;
                sreg_b  <= op_b;
                cin_lat <= op_cin;
                bit_cnt <= '0;
            end else if (bit_valid) begin
                // Zero fill leaves a/b low once the word has fully drained.
                sreg_a <= sreg_a >> 1;
                sreg_b <= sreg_b >> 1;
                if (last_bit) begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/serial_operand_loader.md
Name: serial_operand_loader

Overview:
- Upstream feeder for the bit-serial adder stage.
- Accepts a pair of parallel operands plus a carry-in over a valid/ready handshake.
- Shifts the operands out LSB-first, one bit per enabled clock, on the adder's serial a/b/cin inputs, with framing strobes.
- Supports zero-bubble back-to-back loads, so consecutive operand words stream without idle cycles.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  op_a/op_b/op_cin valid
- in_ready  output  1  loader can accept an operand pair this cycle
- op_a  input  WIDTH  parallel operand A
- op_b  input  WIDTH  parallel operand B
- op_cin  input  1  carry-in for this word
- ser_en  input  1  downstream shift enable; 0 stalls the serial stream
- a  output  1  serial bit of A, LSB first
- b  output  1  serial bit of B, LSB first
- cin  output  1  op_cin during the first bit of a word, else 0
- bit_valid  output  1  a/b/cin valid and consumed this cycle
- first_bit  output  1  current bit is bit 0 of a word
- last_bit  output  1  current bit is bit WIDTH-1 of a word
- busy  output  1  word in flight (state SHIFT)
- done  output  1  one-cycle pulse after the last bit is consumed

Behaviour:
- Reset:
  - rst_n low asynchronously forces state=IDLE, shift registers=0, bit_cnt=0, cin latch=0, done=0.
  - All outputs are 0 during and after reset until a load, except in_ready=1 once rst_n is high.
  - A word in flight at reset is discarded; no done pulse.
- States:
  - IDLE: no word loaded.
  - SHIFT: word loaded, bits pending.
- Load:
  - Occurs when in_valid && in_ready is sampled at a rising edge.
  - Captures op_a, op_b and op_cin into internal registers and clears bit_cnt.
  - State becomes SHIFT.
  - Latency: bit 0 appears on a/b in the cycle after the load edge.
- in_ready:
  - Combinational: (state==IDLE) || (state==SHIFT && last_bit && ser_en).
  - Never depends on in_valid.
- Serial outputs (combinational from registers):
  - a = sreg_a[0], b = sreg_b[0].
  - first_bit = busy && bit_cnt==0.
  - last_bit = busy && bit_cnt==WIDTH-1.
  - cin = first_bit ? latched op_cin : 0.
  - bit_valid = busy && ser_en.
- Shift, each edge with busy && ser_en:
  - sreg_a and sreg_b shift right by 1 with zero fill.
  - bit_cnt increments.
  - At bit_cnt==WIDTH-1:
    - If a new load occurs on the same edge, the new word is loaded and state stays SHIFT (zero bubble).
    - Otherwise state goes to IDLE.
- Stall:
  - With ser_en=0, registers, bit_cnt and the a/b/cin values hold; bit_valid=0.
  - ser_en is ignored in IDLE.
- in_valid held with in_ready=0: the operand is not captured; the source must hold its data stable.
- done:
  - Registered; 1 for exactly one cycle following the edge on which the last bit was consumed.
  - Asserts even when a new word is loaded on the same edge.
- Width rules:
  - bit_cnt is clog2(WIDTH) bits wide.
  - No arithmetic is performed on the operands.
  - Exactly WIDTH bits are emitted per word, each exactly once.

Test Plan:
- Reset then single word: WIDTH=4, op_a=4'b1011, op_b=4'b0110, op_cin=1, ser_en=1 → a sequence 1,1,0,1; b sequence 0,1,1,0; cin 1,0,0,0; first_bit on bit 0, last_bit on bit 3; done pulse the cycle after bit 3; in_ready returns to 1.
- Back-to-back: in_valid held with words 4'hF/4'h1 then 4'h3/4'h3 → 8 consecutive bit_valid cycles with no gap; in_ready=1 only in IDLE and on the last-bit cycles; two done pulses.
- Stall: ser_en=0 for 3 cycles after bit 1 of 4'b1010 → a holds at 1 and bit_valid=0 for 3 cycles; stream resumes with bits 0,1 afterwards; total bits emitted = 4.
- Stall on last bit: ser_en=0 while last_bit=1 and in_valid=1 → in_ready=0 and no load; load occurs on the first edge where ser_en=1.
- Reset mid-word: rst_n low after bit 2 → all outputs 0 immediately, no done pulse; next load streams correctly from bit 0.
- Randomized WIDTH=8 regression: 200 words fed into the serial adder model → every emitted bit and carry-in matches the reference LSB-first serialization.
